vector_execute_unit: RTL and testbench
======================================

# vector_execute_unit

Parametrised execute stage for the vector ASIP. Captures two V-element source vectors and a scalar, then streams them through L parallel lane ALUs over ceil(V/L) passes under a start/done handshake. Tail lanes in the last pass are masked off, and the results are reassembled into a V-element result register. It sits between the register-read stage and writeback, and also executes pure-scalar operations on lane 0.

## Interface
- N, 32, element width in bits
- V, 20, elements per vector
- L, 4, lane ALUs; 1 ≤ L ≤ V
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-high
- start_i  in  1  request; sampled only in IDLE
- OpType  in  2  00 vector-vector, 01 vector-scalar, 10 scalar, 11 reserved
- ALUControl  in  2  00 add, 01 sub, 10 and, 11 or
- RD1_VEC_i  in  V×N  source vector A
- RD2_VEC_i  in  V×N  source vector B
- Scalar_i  in  N  scalar operand
- busy_o  out  1  high while in RUN
- done_o  out  1  one-cycle completion pulse
- result_vec_o  out  V×N  vector result register
- result_scalar_o  out  N  scalar result register
- flags_o  out  2  [1] negative, [0] zero

## Operation
- States are IDLE, RUN and DONE. All inputs are sampled only on a start_i edge in IDLE.
- Passes: P = ceil(V/L). Pass p drives element e = p·L + k into lane k, for k in 0..L-1.
- Lane k is valid only when e < V. Invalid lanes are neither written nor included in flags.
- Operands per OpType:
  - 00: A = RD1[e], B = RD2[e].
  - 01: A = RD1[e], B = Scalar_i broadcast to all lanes.
  - 10: lane 0 only, with A = Scalar_i and B = RD2[0]. The result goes to result_scalar_o. result_vec_o is unchanged.
  - 11: no ALU activity. Both results are unchanged and flags are unchanged.
- Start handling: IDLE and start_i go to RUN. The operands, OpType and ALUControl are latched, and the pass counter is cleared to 0.
- RUN: each cycle writes the valid lanes of pass p, then increments p.
  - After pass P-1 the FSM goes to DONE.
  - Scalar and reserved ops take exactly one RUN cycle.
- DONE: done_o = 1 for one cycle, then the FSM returns to IDLE. start_i in DONE is ignored.
- start_i in RUN or DONE is ignored and has no queuing.
- Arithmetic is modulo 2^N; carry and overflow are discarded.
- The latched operands are stable for the whole operation. Changes on the inputs during RUN have no effect.

## Timing
- Reset value of every output is 0, and the FSM enters IDLE. The pass counter and operand latches are also cleared.
- Start seen at edge t0:
  - busy_o is high for cycles t0..t0+P_eff, with P_eff = P for vector ops and 1 otherwise.
  - done_o is high in the cycle after edge t0+P_eff.
- For V=20, L=4: vector latency is 5 RUN cycles plus 1 DONE cycle. Back-to-back issue is possible every P_eff+2 cycles.
- result_vec_o, result_scalar_o and flags_o are final when done_o rises. They hold until the next operation writes them.
- Partial vector results are visible during RUN and are not guaranteed meaningful.
- RST asserted mid-RUN clears everything immediately. No done_o is produced, and the next start in IDLE is accepted normally.

## Configuration
- VEU_FLAGS_EN defined:
  - flags_o[1] is the OR of sign bits over all valid elements of the operation.
  - flags_o[0] is the AND of zero-detect over all valid elements.
  - For scalar ops, flags come from lane 0 alone.
  - flags_o updates on the edge entering DONE.
- VEU_FLAGS_EN undefined: flags_o is tied to 0 and the flag accumulation logic is absent.

## Structure
- Package veu_pkg holds:
  - optype_t enum and alu_op_t enum, with the encodings above.
  - FLAG_N and FLAG_Z index constants.
  - veu_state_t enum.
  - A passes(V,L) ceiling function.
- Sub-module veu_lane_alu (N-bit ALU with two flag outputs) is instantiated L times. The FSM, pass counter, lane steering, tail mask and result writeback stay in vector_execute_unit.

## Test plan
- V=20, L=4, OpType 00 add, RD1[e]=e, RD2[e]=100 → result[e]=100+e; busy_o high for 5 cycles; done_o pulses once, 6 cycles after start.
- OpType 01 sub, RD1[e]=e, Scalar_i=5 → result[0]=0xFFFFFFFB, result[5]=0, result[19]=14. With VEU_FLAGS_EN: flags_o=2'b10.
- V=20, L=8 (P=3, tail of 4 masked), and/or ops, with result_vec_o preloaded to 0xDEADBEEF → all 20 elements correct, no out-of-range access, done_o 4 cycles after start.
- OpType 10 and, Scalar_i=0x0F0F, RD2[0]=0x00FF → result_scalar_o=0x000F after 1 RUN cycle; result_vec_o unchanged.
- RST pulsed after 2 passes of a vector add → all outputs 0 and no done_o. A fresh start completes correctly.
- start_i held high through RUN and DONE → exactly one operation and one done_o. A new start is accepted only in IDLE, two cycles after done_o.

Source files
------------

// File: rtl/veu_pkg.sv
// Shared types and helpers for the vector execute unit.
// Pure declarations; no logic and no latency.
// No flow control; consumers own all handshaking.
package veu_pkg;

    typedef enum logic [1:0] {
        OP_VV  = 2'b00,
        OP_VS  = 2'b01,
        OP_SC  = 2'b10,
        OP_RSV = 2'b11
    } optype_t;

    typedef enum logic [1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } veu_state_t;

    localparam int FLAG_N = 1;
    localparam int FLAG_Z = 0;

    // Number of lane passes needed to cover v elements with l lanes.
    function automatic int passes(input int v, input int l);
        return (v + l - 1) / l;
    endfunction

endpackage

// File: rtl/vector_execute_unit_if.sv
// Request/result bundle between register-read, the execute unit and writeback.
// Wires only; timing is owned by the execute unit.
// start_i is a level request honoured only when the unit is idle.
interface vector_execute_unit_if #(
    parameter int N = 32,
    parameter int V = 20
);
    import veu_pkg::*;

    logic             start_i;
    optype_t          OpType;
    alu_op_t          ALUControl;
    logic [V*N-1:0]   RD1_VEC_i;
    logic [V*N-1:0]   RD2_VEC_i;
    logic [N-1:0]     Scalar_i;
    logic             busy_o;
    logic             done_o;
    logic [V*N-1:0]   result_vec_o;
    logic [N-1:0]     result_scalar_o;
    logic [1:0]       flags_o;

    // Requester side (register-read stage)
    modport master (
        output start_i, OpType, ALUControl, RD1_VEC_i, RD2_VEC_i, Scalar_i,
        input  busy_o, done_o, result_vec_o, result_scalar_o, flags_o
    );

    // Execute unit side
    modport slave (
        input  start_i, OpType, ALUControl, RD1_VEC_i, RD2_VEC_i, Scalar_i,
        output busy_o, done_o, result_vec_o, result_scalar_o, flags_o
    );

endinterface

// File: rtl/veu_lane_alu.sv
// One N-bit lane ALU: add/sub/and/or, modulo 2^N, plus sign/zero of the result (VEU_FLAGS_EN).
// Purely combinational, zero cycles.
// No backpressure; the caller decides when the result is consumed.
module veu_lane_alu
    import veu_pkg::*;
#(
    parameter int N = 32
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  alu_op_t      op,
    output logic [N-1:0] y
`ifdef VEU_FLAGS_EN
    ,
    output logic         neg,
    output logic         zero
`endif
);

    // Lane datapath; carry and overflow are intentionally dropped
    always_comb begin
        y = '0;
        case (op)
            ALU_ADD: y = a + b;
            ALU_SUB: y = a - b;
            ALU_AND: y = a & b;
            ALU_OR:  y = a | b;
            default: y = '0;
        endcase
    end

`ifdef VEU_FLAGS_EN
    assign neg  = y[N-1];
    assign zero = (y == '0);
`endif

endmodule

// File: rtl/vector_execute_unit.sv
// Vector execute stage: latches A/B/scalar, streams ceil(V/L) passes through L lane ALUs (VEU_FLAGS_EN adds N/Z flags).
// Latency: P passes of RUN (1 for scalar/reserved) then a one-cycle DONE pulse.
// start_i is only sampled in IDLE; requests during RUN/DONE are dropped, not queued.
module vector_execute_unit
    import veu_pkg::*;
#(
    parameter int N = 32,
    parameter int V = 20,
    parameter int L = 4
) (
    input  logic CLK,
    input  logic RST,
    vector_execute_unit_if.slave bus
);

    localparam int P  = passes(V, L);
    localparam int PW = (P > 1) ? $clog2(P) : 1;

    veu_state_t      state_q;
    logic [PW-1:0]   pass_q;
    optype_t         op_q;
    alu_op_t         alu_q;
    logic [V*N-1:0]  rd1_q;
    logic [V*N-1:0]  rd2_q;
    logic [N-1:0]    scalar_q;
    logic            busy_q;
    logic            done_q;
    logic [V*N-1:0]  res_vec_q;
    logic [N-1:0]    res_sc_q;

    logic [N-1:0]    lane_a [L];
    logic [N-1:0]    lane_b [L];
    logic [N-1:0]    lane_y [L];

    logic            is_vec;
    logic            last_pass;

    assign is_vec    = (op_q == OP_VV) || (op_q == OP_VS);
    assign last_pass = (pass_q == PW'(P - 1));

    // Steer the elements of the current pass onto the lanes; tail lanes stay at zero
    always_comb begin
        for (int k = 0; k < L; k++) begin
            lane_a[k] = '0;
            lane_b[k] = '0;
        end
        for (int e = 0; e < V; e++) begin
            if (pass_q == PW'(e / L)) begin
                lane_a[e % L] = rd1_q[e*N +: N];
                lane_b[e % L] = (op_q == OP_VS) ? scalar_q : rd2_q[e*N +: N];
            end
        end
        if (op_q == OP_SC) begin
            lane_a[0] = scalar_q;
            lane_b[0] = rd2_q[N-1:0];
        end
    end

`ifdef VEU_FLAGS_EN
    logic [L-1:0] lane_vld;
    logic [L-1:0] lane_n;
    logic [L-1:0] lane_z;
    logic         pass_n, pass_z;
    logic         acc_n, acc_z;
    logic         nxt_n, nxt_z;
    logic [1:0]   flags_q;
`endif

    for (genvar k = 0; k < L; k++) begin : g_lane
        veu_lane_alu #(.N(N)) u_alu (
            .a    (lane_a[k]),
            .b    (lane_b[k]),
            .op   (alu_q),
            .y    (lane_y[k])
`ifdef VEU_FLAGS_EN
            ,
            .neg  (lane_n[k]),
            .zero (lane_z[k])
`endif
        );
    end

    // Control FSM, operand latches, pass counter and result writeback
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_IDLE;
            pass_q    <= '0;
            op_q      <= OP_VV;
            alu_q     <= ALU_ADD;
            rd1_q     <= '0;
            rd2_q     <= '0;
            scalar_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            res_vec_q <= '0;
            res_sc_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (bus.start_i) begin
                        op_q     <= bus.OpType;
                        alu_q    <= bus.ALUControl;
                        rd1_q    <= bus.RD1_VEC_i;
                        rd2_q    <= bus.RD2_VEC_i;
                        scalar_q <= bus.Scalar_i;
                        pass_q   <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (is_vec) begin
                        // Only elements belonging to this pass are written; tail lanes never map here
                        for (int e = 0; e < V; e++) begin
                            if (pass_q == PW'(e / L)) begin
                                res_vec_q[e*N +: N] <= lane_y[e % L];
                            end
                        end
                    end else if (op_q == OP_SC) begin
                        res_sc_q <= lane_y[0];
                    end
                    if (!is_vec || last_pass) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        pass_q <= pass_q + 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

`ifdef VEU_FLAGS_EN
    // Mark which lanes carry a real element in the current pass
    always_comb begin
        lane_vld = '0;
        for (int e = 0; e < V; e++) begin
            if (pass_q == PW'(e / L)) begin
                lane_vld[e % L] = 1'b1;
            end
        end
    end

    // Fold this pass's valid lanes into the running flags; pass 0 restarts the fold
    always_comb begin
        pass_n = 1'b0;
        pass_z = 1'b1;
        for (int k = 0; k < L; k++) begin
            if (lane_vld[k]) begin
                pass_n = pass_n | lane_n[k];
                pass_z = pass_z & lane_z[k];
            end
        end
        nxt_n = pass_n | ((pass_q == '0) ? 1'b0 : acc_n);
        nxt_z = pass_z & ((pass_q == '0) ? 1'b1 : acc_z);
    end

    // Flag accumulators; the visible flags only change on the edge into DONE
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            acc_n   <= 1'b0;
            acc_z   <= 1'b0;
            flags_q <= '0;
        end else if (state_q == S_RUN) begin
            case (op_q)
                OP_VV, OP_VS: begin
                    acc_n <= nxt_n;
                    acc_z <= nxt_z;
                    if (last_pass) begin
                        flags_q[FLAG_N] <= nxt_n;
                        flags_q[FLAG_Z] <= nxt_z;
                    end
                end
                OP_SC: begin
                    flags_q[FLAG_N] <= lane_n[0];
                    flags_q[FLAG_Z] <= lane_z[0];
                end
                default: ;
            endcase
        end
    end

    assign bus.flags_o = flags_q;
`else
    assign bus.flags_o = '0;
`endif

    assign bus.busy_o          = busy_q;
    assign bus.done_o          = done_q;
    assign bus.result_vec_o    = res_vec_q;
    assign bus.result_scalar_o = res_sc_q;

endmodule

// File: tb/tb_vector_execute_unit.sv
// Self-checking bench for vector_execute_unit with L=4 and L=8 instances.
// Table-driven directed cases, hand-written corner sequences, then random ops vs a reference model.
// Stimulus is only issued when the selected unit is idle.
module tb_vector_execute_unit;
    import veu_pkg::*;

    localparam int N = 32;
    localparam int V = 20;
`ifdef VEU_FLAGS_EN
    localparam bit FLAGS_EN = 1'b1;
`else
    localparam bit FLAGS_EN = 1'b0;
`endif

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    vector_execute_unit_if #(.N(N), .V(V)) if4 ();
    vector_execute_unit_if #(.N(N), .V(V)) if8 ();

    vector_execute_unit #(.N(N), .V(V), .L(4)) u4 (.CLK(CLK), .RST(RST), .bus(if4.slave));
    vector_execute_unit #(.N(N), .V(V), .L(8)) u8 (.CLK(CLK), .RST(RST), .bus(if8.slave));

    logic           start = 1'b0;
    int             sel = 0;
    optype_t        t_in = OP_VV;
    alu_op_t        a_in = ALU_ADD;
    logic [V*N-1:0] rd1 = '0;
    logic [V*N-1:0] rd2 = '0;
    logic [N-1:0]   scal = '0;

    assign if4.start_i    = start && (sel == 0);
    assign if8.start_i    = start && (sel == 1);
    assign if4.OpType     = t_in;
    assign if8.OpType     = t_in;
    assign if4.ALUControl = a_in;
    assign if8.ALUControl = a_in;
    assign if4.RD1_VEC_i  = rd1;
    assign if8.RD1_VEC_i  = rd1;
    assign if4.RD2_VEC_i  = rd2;
    assign if8.RD2_VEC_i  = rd2;
    assign if4.Scalar_i   = scal;
    assign if8.Scalar_i   = scal;

    logic           busy, done;
    logic [V*N-1:0] rvec;
    logic [N-1:0]   rsc;
    logic [1:0]     fl;

    always_comb begin
        if (sel == 0) begin
            busy = if4.busy_o; done = if4.done_o; rvec = if4.result_vec_o;
            rsc = if4.result_scalar_o; fl = if4.flags_o;
        end else begin
            busy = if8.busy_o; done = if8.done_o; rvec = if8.result_vec_o;
            rsc = if8.result_scalar_o; fl = if8.flags_o;
        end
    end

    // Reference model state per instance
    logic [V*N-1:0] m_vec [2];
    logic [N-1:0]   m_sc  [2];
    logic [1:0]     m_fl  [2];

    int n_tests = 0;
    int n_fail  = 0;

    function automatic logic [N-1:0] alu_ref(alu_op_t a, logic [N-1:0] x, logic [N-1:0] y);
        case (a)
            ALU_ADD: return x + y;
            ALU_SUB: return x - y;
            ALU_AND: return x & y;
            default: return x | y;
        endcase
    endfunction

    task automatic apply_model(input int s);
        logic [N-1:0] r;
        logic n_acc, z_acc;
        n_acc = 1'b0;
        z_acc = 1'b1;
        if (t_in == OP_VV || t_in == OP_VS) begin
            for (int e = 0; e < V; e++) begin
                r = alu_ref(a_in, rd1[e*N +: N], (t_in == OP_VV) ? rd2[e*N +: N] : scal);
                m_vec[s][e*N +: N] = r;
                n_acc = n_acc | r[N-1];
                z_acc = z_acc & (r == '0);
            end
            if (FLAGS_EN) m_fl[s] = {n_acc, z_acc};
        end else if (t_in == OP_SC) begin
            r = alu_ref(a_in, scal, rd2[N-1:0]);
            m_sc[s] = r;
            if (FLAGS_EN) m_fl[s] = {r[N-1], (r == '0)};
        end
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [V*N-1:0] act, input logic [V*N-1:0] exp);
        int bad;
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            bad = 0;
            for (int e = V - 1; e >= 0; e--) if (act[e*N +: N] !== exp[e*N +: N]) bad = e;
            $display("FAIL %s: element %0d got %h, expected %h", name, bad, act[bad*N +: N], exp[bad*N +: N]);
        end
    endtask

    // Issue one op on instance s and check handshake timing and final results against the model
    task automatic do_op(input int s, input optype_t t, input alu_op_t a,
                         input logic [V*N-1:0] r1, input logic [V*N-1:0] r2,
                         input logic [N-1:0] sc, input bit hold, input string tag);
        int p_eff, busy_cnt, done_at, done_cnt;
        logic [V*N-1:0] snap_vec;
        logic [N-1:0]   snap_sc;
        logic [1:0]     snap_fl;
        p_eff = (t == OP_VV || t == OP_VS) ? passes(V, (s == 0) ? 4 : 8) : 1;
        @(negedge CLK);
        sel = s; t_in = t; a_in = a; rd1 = r1; rd2 = r2; scal = sc; start = 1'b1;
        apply_model(s);
        busy_cnt = 0; done_at = 0; done_cnt = 0;
        snap_vec = '0; snap_sc = '0; snap_fl = '0;
        for (int c = 1; c <= p_eff + 2; c++) begin
            @(negedge CLK);
            if (!hold) begin
                start = 1'b0;
                // Inputs wander during RUN; latched operands must be used
                for (int e = 0; e < V; e++) begin
                    rd1[e*N +: N] = $urandom;
                    rd2[e*N +: N] = $urandom;
                end
                scal = $urandom;
            end
            if (busy) busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = c;
            end
            if (c == p_eff + 1) begin
                snap_vec = rvec; snap_sc = rsc; snap_fl = fl;
            end
        end
        check({tag, " busy cycles"}, 64'(busy_cnt), 64'(p_eff));
        check({tag, " done cycle"}, 64'(done_at), 64'(p_eff + 1));
        check({tag, " done pulses"}, 64'(done_cnt), 64'd1);
        check_vec({tag, " result_vec"}, snap_vec, m_vec[s]);
        check({tag, " result_scalar"}, 64'(snap_sc), 64'(m_sc[s]));
        check({tag, " flags"}, 64'(snap_fl), 64'(m_fl[s]));
    endtask

    typedef struct {
        optype_t     t;
        alu_op_t     a;
        logic [31:0] b1, s1, b2, sc;
        logic [31:0] r0, r5, r19, esc;
        logic [1:0]  fl;
    } vec_t;

    vec_t tbl [6];

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: time limit reached, expected bench completion");
        $fatal(1);
    end

    initial begin : main
        logic [V*N-1:0] v1, v2;
        int done_cnt;
        bit seen;

        for (int s = 0; s < 2; s++) begin
            m_vec[s] = '0; m_sc[s] = '0; m_fl[s] = '0;
        end

        // rd1[e] = b1 + s1*e, rd2[e] = b2; expected elements 0, 5, 19, scalar, flags
        tbl[0] = '{OP_VV,  ALU_ADD, 32'd0,        32'd1, 32'd100,   32'd0,      32'd100,      32'd105,      32'd119,      32'h0, 2'b00};
        tbl[1] = '{OP_VS,  ALU_SUB, 32'd0,        32'd1, 32'd0,     32'd5,      32'hFFFFFFFB, 32'd0,        32'd14,       32'h0, 2'b10};
        tbl[2] = '{OP_SC,  ALU_AND, 32'd0,        32'd1, 32'h00FF,  32'h0F0F,   32'hFFFFFFFB, 32'd0,        32'd14,       32'hF, 2'b00};
        tbl[3] = '{OP_VV,  ALU_AND, 32'd0,        32'd1, 32'd0,     32'd0,      32'd0,        32'd0,        32'd0,        32'hF, 2'b01};
        tbl[4] = '{OP_RSV, ALU_ADD, 32'd7,        32'd3, 32'd9,     32'd1,      32'd0,        32'd0,        32'd0,        32'hF, 2'b01};
        tbl[5] = '{OP_VS,  ALU_OR,  32'h80000000, 32'd1, 32'd0,     32'd0,      32'h80000000, 32'h80000005, 32'h80000013, 32'hF, 2'b10};

        // Reset state of both instances
        repeat (3) @(negedge CLK);
        for (int s = 0; s < 2; s++) begin
            sel = s;
            #1;
            check("reset busy", 64'(busy), 64'd0);
            check("reset done", 64'(done), 64'd0);
            check_vec("reset result_vec", rvec, '0);
            check("reset result_scalar", 64'(rsc), 64'd0);
            check("reset flags", 64'(fl), 64'd0);
        end
        @(negedge CLK);
        RST = 1'b0;

        // Directed table on the L=4 instance
        for (int i = 0; i < 6; i++) begin
            for (int e = 0; e < V; e++) begin
                v1[e*N +: N] = tbl[i].b1 + tbl[i].s1 * 32'(e);
                v2[e*N +: N] = tbl[i].b2;
            end
            do_op(0, tbl[i].t, tbl[i].a, v1, v2, tbl[i].sc, 1'b0, $sformatf("tbl%0d", i));
            check($sformatf("tbl%0d elem0", i),  64'(rvec[0*N +: N]),  64'(tbl[i].r0));
            check($sformatf("tbl%0d elem5", i),  64'(rvec[5*N +: N]),  64'(tbl[i].r5));
            check($sformatf("tbl%0d elem19", i), 64'(rvec[19*N +: N]), 64'(tbl[i].r19));
            check($sformatf("tbl%0d scalar", i), 64'(rsc), 64'(tbl[i].esc));
            check($sformatf("tbl%0d flags", i),  64'(fl), FLAGS_EN ? 64'(tbl[i].fl) : 64'd0);
        end

        // start_i held high: one op, one done, restart only once back in IDLE
        for (int e = 0; e < V; e++) begin
            v1[e*N +: N] = 32'd50 + 32'(e);
            v2[e*N +: N] = 32'(e);
        end
        do_op(0, OP_VV, ALU_SUB, v1, v2, 32'd0, 1'b1, "hold");
        @(negedge CLK);
        check("hold restart accepted in idle", 64'(busy), 64'd1);
        start = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (done) seen = 1'b1;
        end
        check("hold second op done", 64'(seen), 64'd1);
        @(negedge CLK);
        check_vec("hold second op result", rvec, m_vec[0]);

        // L=8: preload 0xDEADBEEF, then and/or ops across the masked tail
        for (int e = 0; e < V; e++) v1[e*N +: N] = 32'hDEADBEEF;
        do_op(1, OP_VV, ALU_OR, v1, '0, 32'd0, 1'b0, "l8 preload");
        check("l8 preload elem19", 64'(rvec[19*N +: N]), 64'hDEADBEEF);
        for (int e = 0; e < V; e++) begin
            v1[e*N +: N] = $urandom;
            v2[e*N +: N] = $urandom;
        end
        do_op(1, OP_VV, ALU_AND, v1, v2, 32'd0, 1'b0, "l8 and");
        do_op(1, OP_VS, ALU_OR, v2, v1, 32'h00F0000F, 1'b0, "l8 or");

        // Reset in the middle of a vector add on L=4
        @(negedge CLK);
        sel = 0; t_in = OP_VV; a_in = ALU_ADD; scal = '0;
        for (int e = 0; e < V; e++) begin
            rd1[e*N +: N] = 32'(e);
            rd2[e*N +: N] = 32'd1000;
        end
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("midrun busy", 64'(busy), 64'd1);
        RST = 1'b1;
        #1;
        check("midrun reset busy", 64'(busy), 64'd0);
        check("midrun reset done", 64'(done), 64'd0);
        check_vec("midrun reset result_vec", rvec, '0);
        check("midrun reset result_scalar", 64'(rsc), 64'd0);
        check("midrun reset flags", 64'(fl), 64'd0);
        for (int s = 0; s < 2; s++) begin
            m_vec[s] = '0; m_sc[s] = '0; m_fl[s] = '0;
        end
        @(negedge CLK);
        RST = 1'b0;
        done_cnt = 0;
        repeat (10) begin
            @(negedge CLK);
            if (done) done_cnt++;
        end
        check("midrun no done after reset", 64'(done_cnt), 64'd0);
        for (int e = 0; e < V; e++) begin
            v1[e*N +: N] = 32'(e);
            v2[e*N +: N] = 32'd100;
        end
        do_op(0, OP_VV, ALU_ADD, v1, v2, 32'd0, 1'b0, "post reset");

        // Random ops on both instances
        for (int i = 0; i < 24; i++) begin
            for (int e = 0; e < V; e++) begin
                v1[e*N +: N] = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
                v2[e*N +: N] = $urandom;
            end
            do_op(int'($urandom_range(0, 1)), optype_t'($urandom_range(0, 3)),
                  alu_op_t'($urandom_range(0, 3)), v1, v2, $urandom, 1'b0,
                  $sformatf("rand%0d", i));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
